// File: rtl/vec_pkg.sv
// Shared constants, state encoding and lane helper for the vector memory sequencer.
package vec_pkg;

   localparam int LANES  = 4;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int VEC_W  = LANES * DATA_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } vms_state_t;

   // Low bit of lane idx within the vector; lane 0 sits in the top byte.
   function automatic logic [4:0] lane_slice(input logic [1:0] idx);
      return 5'((31 - 8 * int'(idx)) - 7);
   endfunction

endpackage

// File: rtl/vec_lane_pack.sv
// Four-lane byte capture register; writes one selected lane per enabled cycle.
module vec_lane_pack
   import vec_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              cap_en,
   input  logic [1:0]        lane_idx,
   input  logic [DATA_W-1:0] lane_byte,
   output logic [VEC_W-1:0]  vec
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vec <= '0;
      end else if (cap_en) begin
         vec[lane_slice(lane_idx) +: DATA_W] <= lane_byte;
      end
   end

endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: 4 byte accesses per 32-bit vector.
// Optional macro VEC_MEM_SEQ_STRIDE_EN adds a per-transfer lane address stride.
//
// state | meaning
// IDLE  | waiting for start; latches op, base, wdata (and stride)
// RUN   | four memory cycles, idx = 0..3
// DRAIN | load only: capture last read byte, no memory enables
// DONE  | one-cycle done pulse, rdata_valid for loads
module vec_mem_seq
   import vec_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              op_store,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [VEC_W-1:0]  wdata,
`ifdef VEC_MEM_SEQ_STRIDE_EN
   input  logic [2:0]        stride,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rden,
   output logic              mem_wren,
   output logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] mem_q,
   output logic [VEC_W-1:0]  rdata,
   output logic              rdata_valid
);

   vms_state_t        state, state_nxt;
   logic [1:0]        idx;
   logic              op_q;
   logic [ADDR_W-1:0] base_q;
   logic [VEC_W-1:0]  wdata_q;
   logic [ADDR_W-1:0] lane_off;
   logic              cap_en;
   logic [1:0]        cap_idx;
   logic              accept;

`ifdef VEC_MEM_SEQ_STRIDE_EN
   logic [2:0]        stride_q;
`else
   localparam logic [2:0] stride_q = 3'd1;
`endif

   assign accept   = (state == IDLE) && start;
   assign lane_off = ADDR_W'(idx) * ADDR_W'(stride_q);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         idx     <= 2'd0;
         op_q    <= 1'b0;
         base_q  <= '0;
         wdata_q <= '0;
`ifdef VEC_MEM_SEQ_STRIDE_EN
         stride_q <= 3'd0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            idx     <= 2'd0;
            op_q    <= op_store;
            base_q  <= base_addr;
            wdata_q <= wdata;
`ifdef VEC_MEM_SEQ_STRIDE_EN
            stride_q <= stride;
`endif
         end else if (state == RUN) begin
            idx <= idx + 2'd1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      busy        = (state != IDLE);
      done        = 1'b0;
      rdata_valid = 1'b0;
      mem_addr    = '0;
      mem_rden    = 1'b0;
      mem_wren    = 1'b0;
      mem_data    = '0;
      cap_en      = 1'b0;
      cap_idx     = idx - 2'd1;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            mem_addr = base_q + lane_off;
            mem_rden = ~op_q;
            mem_wren = op_q;
            if (op_q) mem_data = wdata_q[lane_slice(idx) +: DATA_W];
            // read data lags the address by one cycle, so lane idx-1 lands now
            cap_en = ~op_q && (idx != 2'd0);
            if (idx == 2'd3) state_nxt = op_q ? DONE : DRAIN;
         end
         DRAIN: begin
            cap_en    = 1'b1;
            cap_idx   = 2'd3;
            state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            rdata_valid = ~op_q;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   vec_lane_pack u_lane_pack (
      .clock     (clock),
      .reset     (reset),
      .cap_en    (cap_en),
      .lane_idx  (cap_idx),
      .lane_byte (mem_q),
      .vec       (rdata)
   );

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed and randomized bench for vec_mem_seq against a byte-array memory model.
module tb_vec_mem_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        op_store;
   logic [7:0]  base_addr;
   logic [31:0] wdata;
   logic        busy, done, mem_rden, mem_wren, rdata_valid;
   logic [7:0]  mem_addr, mem_data;
   logic [7:0]  mem_q;
   logic [31:0] rdata;
`ifdef VEC_MEM_SEQ_STRIDE_EN
   logic [2:0]  stride_in;
`endif

   logic [7:0]  mem     [256];
   logic [7:0]  exp_mem [256];
   logic [31:0] last_rdata;
   int          checks   = 0;
   int          failures = 0;

   always #5 clock = ~clock;

   vec_mem_seq dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op_store    (op_store),
      .base_addr   (base_addr),
      .wdata       (wdata),
`ifdef VEC_MEM_SEQ_STRIDE_EN
      .stride      (stride_in),
`endif
      .busy        (busy),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_rden    (mem_rden),
      .mem_wren    (mem_wren),
      .mem_data    (mem_data),
      .mem_q       (mem_q),
      .rdata       (rdata),
      .rdata_valid (rdata_valid)
   );

   // Synchronous byte memory: read data registered, one cycle after address.
   always @(posedge clock) begin
      mem_q <= mem[mem_addr];
      if (mem_wren) mem[mem_addr] = mem_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_rden"}, 32'(mem_rden), 32'd0);
      chk({tag, "_wren"}, 32'(mem_wren), 32'd0);
      chk({tag, "_valid"}, 32'(rdata_valid), 32'd0);
   endtask

   task automatic do_op(input string name, input logic op, input logic [7:0] base,
                        input logic [31:0] wd, input logic [2:0] st, input bit poke);
      logic [7:0]  a [4];
      logic [31:0] expv;
      int          len;
      for (int i = 0; i < 4; i++) a[i] = base + 8'(i) * 8'(st);
      expv = {exp_mem[a[0]], exp_mem[a[1]], exp_mem[a[2]], exp_mem[a[3]]};
      if (op) for (int i = 0; i < 4; i++) exp_mem[a[i]] = wd[31-8*i -: 8];
      len = op ? 5 : 6;
      @(negedge clock);
      start     = 1'b1;
      op_store  = op;
      base_addr = base;
      wdata     = wd;
`ifdef VEC_MEM_SEQ_STRIDE_EN
      stride_in = st;
`endif
      for (int c = 1; c <= len + 2; c++) begin
         @(negedge clock);
         start = poke && (c == 2 || c == 5);
         if (start) begin
            op_store  = ~op;
            base_addr = ~base;
         end
         if (c <= 4) begin
            chk($sformatf("%s_c%0d_busy", name, c), 32'(busy), 32'd1);
            chk($sformatf("%s_c%0d_addr", name, c), 32'(mem_addr), 32'(a[c-1]));
            chk($sformatf("%s_c%0d_rden", name, c), 32'(mem_rden), 32'(!op));
            chk($sformatf("%s_c%0d_wren", name, c), 32'(mem_wren), 32'(op));
            chk($sformatf("%s_c%0d_done", name, c), 32'(done), 32'd0);
            if (op) chk($sformatf("%s_c%0d_data", name, c), 32'(mem_data), 32'(wd[31-8*(c-1) -: 8]));
         end else if (c < len) begin
            chk($sformatf("%s_drain_busy", name), 32'(busy), 32'd1);
            chk($sformatf("%s_drain_en", name), {30'd0, mem_rden, mem_wren}, 32'd0);
            chk($sformatf("%s_drain_addr", name), 32'(mem_addr), 32'd0);
            chk($sformatf("%s_drain_done", name), 32'(done), 32'd0);
         end else if (c == len) begin
            chk($sformatf("%s_done", name), 32'(done), 32'd1);
            chk($sformatf("%s_done_valid", name), 32'(rdata_valid), 32'(!op));
            chk($sformatf("%s_done_busy", name), 32'(busy), 32'd1);
            chk($sformatf("%s_done_en", name), {30'd0, mem_rden, mem_wren}, 32'd0);
            chk($sformatf("%s_done_addr", name), 32'(mem_addr), 32'd0);
            chk($sformatf("%s_done_rdata", name), rdata, op ? last_rdata : expv);
         end else begin
            chk_idle_outputs($sformatf("%s_post%0d", name, c - len));
            chk($sformatf("%s_post%0d_rdata", name, c - len), rdata, op ? last_rdata : expv);
         end
      end
      start = 1'b0;
      if (!op) last_rdata = expv;
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s_mem%0d", name, i), 32'(mem[a[i]]), 32'(exp_mem[a[i]]));
   endtask

   initial begin
      logic        r_op;
      logic [7:0]  r_base;
      logic [31:0] r_wd;
      logic [2:0]  r_st;
      reset     = 1'b0;
      start     = 1'b0;
      op_store  = 1'b0;
      base_addr = 8'h00;
      wdata     = 32'h0;
`ifdef VEC_MEM_SEQ_STRIDE_EN
      stride_in = 3'd0;
`endif
      last_rdata = 32'h0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'($urandom);
         exp_mem[i] = mem[i];
      end
      for (int i = 0; i < 4; i++) begin
         mem[8'h10 + i]     = 8'h11 * 8'(i + 1);
         exp_mem[8'h10 + i] = 8'h11 * 8'(i + 1);
      end
      #1;
      chk_idle_outputs("reset");
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_data", 32'(mem_data), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      do_op("load", 1'b0, 8'h10, 32'h0, 3'd1, 1'b0);
      chk("load_vec", last_rdata, 32'h11223344);
      do_op("store", 1'b1, 8'h20, 32'hDEADBEEF, 3'd1, 1'b0);
      chk("store_byte0", 32'(mem[8'h20]), 32'hDE);
      chk("store_byte3", 32'(mem[8'h23]), 32'hEF);
      do_op("wrap", 1'b0, 8'hFE, 32'h0, 3'd1, 1'b0);
      do_op("busy", 1'b0, 8'h50, 32'h0, 3'd1, 1'b1);

      // reset lands in the middle of store cycle 3
      @(negedge clock);
      start = 1'b1; op_store = 1'b1; base_addr = 8'h30; wdata = 32'hCAFEF00D;
`ifdef VEC_MEM_SEQ_STRIDE_EN
      stride_in = 3'd1;
`endif
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      chk_idle_outputs("rst_mid");
      chk("rst_mid_rdata", rdata, 32'h0);
      chk("rst_mid_data", 32'(mem_data), 32'd0);
      last_rdata = 32'h0;
      exp_mem[8'h30] = 8'hCA;
      exp_mem[8'h31] = 8'hFE;
      repeat (2) begin
         @(negedge clock);
         chk("rst_hold_wren", 32'(mem_wren), 32'd0);
      end
      reset = 1'b1;
      repeat (2) begin
         @(negedge clock);
         chk_idle_outputs("rst_after");
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("rst_mem%0d", i), 32'(mem[8'h30 + i]), 32'(exp_mem[8'h30 + i]));
      do_op("post_rst", 1'b0, 8'h30, 32'h0, 3'd1, 1'b0);

`ifdef VEC_MEM_SEQ_STRIDE_EN
      do_op("stride2", 1'b0, 8'h40, 32'h0, 3'd2, 1'b0);
      do_op("stride0", 1'b1, 8'h60, 32'h01234567, 3'd0, 1'b0);
`endif

      for (int n = 0; n < 12; n++) begin
         r_op   = 1'($urandom_range(0, 1));
         r_base = 8'($urandom);
         r_wd   = $urandom;
`ifdef VEC_MEM_SEQ_STRIDE_EN
         r_st   = 3'($urandom_range(0, 7));
`else
         r_st   = 3'd1;
`endif
         do_op($sformatf("rnd%0d", n), r_op, r_base, r_wd, r_st, bit'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
